// File: rtl/fp_mult_pipe_pkg.sv
// Shared types and helpers for the fp_mult_pipe floating-point multiplier:
// default field widths and the final-stage result classification.
`include "fp_defs.vh"

package fp_mult_pipe_pkg;

  localparam int DEF_NB_EXP = `FP_NB_EXP;
  localparam int DEF_NB_MAN = `FP_NB_MAN;

  typedef enum logic [1:0] {
    RC_NORMAL = 2'd0,
    RC_ZERO   = 2'd1,
    RC_OVF    = 2'd2,
    RC_UNF    = 2'd3
  } res_class_e;

  // Zero operands win over range checks; all-ones exponent is an ordinary finite value.
  function automatic res_class_e classify(input logic zero,
                                          input logic signed [31:0] xexp,
                                          input int nb_exp);
    if (zero)
      return RC_ZERO;
    else if (xexp > (2**nb_exp) - 1)
      return RC_OVF;
    else if (xexp <= 0)
      return RC_UNF;
    else
      return RC_NORMAL;
  endfunction

endpackage

// File: rtl/fp_defs.vh
// Shared field-width defaults, bias formula and word slice offsets for the
// {sign, exponent, fraction} floating-point word used by fp_mult_pipe.
`ifndef FP_DEFS_VH
`define FP_DEFS_VH

`define FP_NB_EXP 4
`define FP_NB_MAN 8
`define FP_BIAS(ne) ((2**((ne)-1))-1)

// Bit positions inside a word of width 1+ne+nm, MSB first.
`define FP_SIGN_POS(ne, nm) ((ne)+(nm))
`define FP_EXP_MSB(ne, nm) ((ne)+(nm)-1)
`define FP_EXP_LSB(nm) (nm)
`define FP_FRAC_MSB(nm) ((nm)-1)

`endif

// File: rtl/fp_normalizer.sv
// Combinational normalization of the raw mantissa product: brings the leading
// one to the top fraction position and truncates the bits below the fraction.
module fp_normalizer #(
  parameter  int NB_EXP  = 4,
  parameter  int NB_MAN  = 8,
  localparam int NB_PROD = 2*NB_MAN+2,
  localparam int NB_XE   = NB_EXP+2
) (
  input  logic        [NB_PROD-1:0] i_prod,
  input  logic signed [NB_XE-1:0]   i_exp,
  output logic        [NB_MAN-1:0]  o_frac,
  output logic signed [NB_XE-1:0]   o_exp
);

  logic w_unused_lsbs;
  assign w_unused_lsbs = ^i_prod[NB_MAN-1:0];

  // Product of two 1.x mantissas lies in [1,4): leading one is at one of the top two bits.
  always_comb begin
    o_frac = i_prod[NB_PROD-3 -: NB_MAN];
    o_exp  = i_exp;
    if (i_prod[NB_PROD-1]) begin
      o_frac = i_prod[NB_PROD-2 -: NB_MAN];
      o_exp  = i_exp + NB_XE'(1);
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (no denormals, no Inf/NaN):
// S1 sign/exponent/mantissa product, S2 normalize, S3 range check and output.
`include "fp_defs.vh"

module fp_mult_pipe
  import fp_mult_pipe_pkg::*;
#(
  parameter  int NB_EXP  = DEF_NB_EXP,
  parameter  int NB_MAN  = DEF_NB_MAN,
  parameter  int BIAS    = `FP_BIAS(NB_EXP),
  localparam int NB_WORD = 1+NB_EXP+NB_MAN
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [NB_WORD-1:0] i_flotante_1,
  input  logic [NB_WORD-1:0] i_flotante_2,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [NB_WORD-1:0] o_multiplicado,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int NB_PROD  = 2*NB_MAN+2;
  localparam int NB_XE    = NB_EXP+2;
  localparam int SIGN_POS = `FP_SIGN_POS(NB_EXP, NB_MAN);
  localparam int EXP_MSB  = `FP_EXP_MSB(NB_EXP, NB_MAN);
  localparam int EXP_LSB  = `FP_EXP_LSB(NB_MAN);
  localparam int FRAC_MSB = `FP_FRAC_MSB(NB_MAN);

  // Handshake: an operand pair transfers on a rising edge where i_valid && o_ready;
  // a product transfers where o_valid && i_ready. One enable moves the whole pipe,
  // so a stalled output freezes every stage, valid bits included.
  logic w_en;
  logic r_s3_valid;
  assign w_en    = !r_s3_valid || i_ready;
  assign o_ready = w_en;

  // S1 combinational
  logic        [NB_EXP-1:0]  w_e1, w_e2;
  logic        [NB_MAN:0]    w_m1, w_m2;
  logic                      w_s1_zero;
  logic signed [NB_XE-1:0]   w_s1_exp;
  logic        [NB_PROD-1:0] w_s1_prod;

  assign w_e1      = i_flotante_1[EXP_MSB:EXP_LSB];
  assign w_e2      = i_flotante_2[EXP_MSB:EXP_LSB];
  assign w_m1      = {1'b1, i_flotante_1[FRAC_MSB:0]};
  assign w_m2      = {1'b1, i_flotante_2[FRAC_MSB:0]};
  assign w_s1_zero = (w_e1 == '0) || (w_e2 == '0);
  assign w_s1_exp  = $signed({2'b00, w_e1}) + $signed({2'b00, w_e2}) - NB_XE'(BIAS);
  assign w_s1_prod = {{(NB_MAN+1){1'b0}}, w_m1} * {{(NB_MAN+1){1'b0}}, w_m2};

  logic                      r_s1_valid, r_s1_sign, r_s1_zero;
  logic signed [NB_XE-1:0]   r_s1_exp;
  logic        [NB_PROD-1:0] r_s1_prod;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_prod  <= '0;
    end else if (w_en) begin
      r_s1_valid <= i_valid;
      r_s1_sign  <= i_flotante_1[SIGN_POS] ^ i_flotante_2[SIGN_POS];
      r_s1_zero  <= w_s1_zero;
      r_s1_exp   <= w_s1_exp;
      r_s1_prod  <= w_s1_prod;
    end
  end

  // S2 normalize
  logic        [NB_MAN-1:0] w_n_frac;
  logic signed [NB_XE-1:0]  w_n_exp;

  fp_normalizer #(
    .NB_EXP (NB_EXP),
    .NB_MAN (NB_MAN)
  ) u_normalizer (
    .i_prod (r_s1_prod),
    .i_exp  (r_s1_exp),
    .o_frac (w_n_frac),
    .o_exp  (w_n_exp)
  );

  logic                     r_s2_valid, r_s2_sign, r_s2_zero;
  logic signed [NB_XE-1:0]  r_s2_exp;
  logic        [NB_MAN-1:0] r_s2_frac;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_frac  <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_zero  <= r_s1_zero;
      r_s2_exp   <= w_n_exp;
      r_s2_frac  <= w_n_frac;
    end
  end

  // S3 range check / saturate
  res_class_e         w_class;
  logic [NB_WORD-1:0] w_word;
  logic               w_ovf, w_unf;

  assign w_class = classify(r_s2_zero, 32'(r_s2_exp), NB_EXP);

  always_comb begin
    w_word = '0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    case (w_class)
      RC_ZERO: w_word = {r_s2_sign, {(NB_WORD-1){1'b0}}};
      RC_OVF: begin
        w_word = {r_s2_sign, {(NB_WORD-1){1'b1}}};
        w_ovf  = 1'b1;
      end
      RC_UNF: begin
        w_word = {r_s2_sign, {(NB_WORD-1){1'b0}}};
        w_unf  = 1'b1;
      end
      default: w_word = {r_s2_sign, r_s2_exp[NB_EXP-1:0], r_s2_frac};
    endcase
  end

  logic [NB_WORD-1:0] r_out;
  logic               r_ovf, r_unf;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s3_valid <= 1'b0;
      r_out      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid;
      r_out      <= w_word;
      r_ovf      <= w_ovf;
      r_unf      <= w_unf;
    end
  end

  assign o_valid        = r_s3_valid;
  assign o_multiplicado = r_out;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_unf;

endmodule

// File: doc/fp_mult_pipe.md
FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 SHALL have parameter NB_EXP, default 4, exponent field width.
REQ-002 SHALL have parameter NB_MAN, default 8, stored fraction width (hidden leading 1 implied).
REQ-003 SHALL have parameter BIAS, default 2**(NB_EXP-1)-1 (7 at default), exponent bias.
REQ-004 SHALL have derived localparam NB_WORD = 1+NB_EXP+NB_MAN, word layout {sign, exponent, fraction}, MSB first.
REQ-005 SHALL have port i_clock, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports i_flotante_1 and i_flotante_2, input, NB_WORD each, operands.
REQ-008 SHALL have port i_valid, input, 1, operands valid this cycle.
REQ-009 SHALL have port o_ready, output, 1, block accepts operands this cycle.
REQ-010 SHALL have port o_multiplicado, output, NB_WORD, product.
REQ-011 SHALL have port o_valid, output, 1, product valid.
REQ-012 SHALL have port i_ready, input, 1, downstream accepts product.
REQ-013 SHALL have ports o_overflow and o_underflow, output, 1 each, qualified by o_valid.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 sign XOR, exponent sum, (NB_MAN+1)x(NB_MAN+1) mantissa multiply; S2 normalize; S3 range check/saturate, output register.
REQ-015 SHALL have latency of exactly 3 cycles from accepted input (i_valid && o_ready) to o_valid, when i_ready is held high.
REQ-016 SHALL sustain throughput of one result per cycle when i_ready is held high.
REQ-017 SHALL use a single stage enable, en = !o_valid || i_ready; o_ready = en; when en is low, all stage registers, including valid bits, hold.
REQ-018 SHALL hold o_multiplicado, o_overflow and o_underflow stable while o_valid && !i_ready.
REQ-019 SHALL treat an operand with exponent field 0 as zero regardless of fraction (no denormals).
REQ-020 SHALL give a result of {sign, all zeros} when either operand is zero, with both flags low.
REQ-021 SHALL compute the S1 exponent as e1+e2-BIAS in NB_EXP+2 signed bits, with no intermediate wrap.
REQ-022 SHALL, in S2: if product bit 2*NB_MAN+1 is set, shift the product right by 1 and increment the exponent; then take the fraction as the NB_MAN bits below the leading 1, truncating the rest.
REQ-023 SHALL, if the normalized exponent exceeds 2**NB_EXP-1, output {sign, all ones, all ones} with o_overflow=1.
REQ-024 SHALL, if the normalized exponent is ≤ 0, output {sign, all zeros} with o_underflow=1.
REQ-025 SHALL treat exponent field all-ones as an ordinary finite exponent (no Inf/NaN encoding).
REQ-026 SHALL, when i_valid is low while en is high, inject a bubble: the S1 valid bit clears and the data content is don't-care.

Reset
REQ-027 SHALL, on i_reset_n low, asynchronously clear all valid bits, o_valid, o_overflow, o_underflow and o_multiplicado to 0; o_ready is then 1.
REQ-028 SHALL discard in-flight operations when reset is asserted mid-operation; after deassertion, no output appears until new inputs are accepted.

Structure
REQ-029 SHALL place field-width defaults, BIAS formula and field slice offsets in shared header fp_defs.vh, also used by the bench.
REQ-030 SHALL implement S2 normalization in sub-module fp_normalizer (combinational, parametrised by NB_EXP and NB_MAN).

Verification (defaults NB_EXP=4, NB_MAN=8)
REQ-031 SHALL verify basic product: 0x0780 x 0x0780 (1.5x1.5) -> 0x0820, no flags, o_valid exactly 3 cycles after acceptance.
REQ-032 SHALL verify sign and streaming: back-to-back pairs 0x0800x0x1800, then 0x0700x0x0700 -> 0x1900, then 0x0700 on consecutive cycles.
REQ-033 SHALL verify saturate/flush: 0x0F00x0x0F00 -> 0x0FFF with o_overflow=1; 0x0100x0x0100 -> 0x0000 with o_underflow=1.
REQ-034 SHALL verify zero handling: 0x0000x0x1780 -> 0x1000, flags low; 0x00FFx0x0700 -> 0x0000.
REQ-035 SHALL verify backpressure: i_ready low for 5 cycles with 3 ops in flight -> o_ready low, output held, all 3 results delivered in order with none lost or duplicated.
REQ-036 SHALL verify mid-operation reset: pulse i_reset_n low with 2 ops in flight -> o_valid 0 immediately, no stale result after release.
